// File: rtl/super_counter_pkg.sv
// Shared types and constants for the super-counter status reporting path.
// Holds the sequencer state encoding, message length and ASCII byte values.
package super_counter_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      SEND    = 2'd2,
      GAP     = 2'd3
   } seq_state_t;

   localparam int MSG_LEN = 11;

   localparam logic [7:0] CHAR_B  = 8'h42;
   localparam logic [7:0] CHAR_T  = 8'h54;
   localparam logic [7:0] CHAR_N  = 8'h4E;
   localparam logic [7:0] CHAR_EQ = 8'h3D;
   localparam logic [7:0] CHAR_0  = 8'h30;
   localparam logic [7:0] CHAR_CR = 8'h0D;
   localparam logic [7:0] CHAR_LF = 8'h0A;

   function automatic logic [7:0] digit_char(input logic [3:0] d);
      return CHAR_0 + {4'b0000, d};
   endfunction

endpackage

// File: rtl/bin16_to_bcd5.sv
// Serial double-dabble: 16-bit binary to five BCD digits, done pulses 16 cycles
// after start. The shift register doubles as the snapshot of the input value.
module bin16_to_bcd5 (
   input  logic        clk_12m,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] bin,
   output logic        done,
   output logic [19:0] bcd
);

   logic [15:0] shift_reg;
   logic [19:0] bcd_reg;
   logic [3:0]  step_reg;
   logic        run_reg;
   logic        done_reg;
   logic [19:0] bcd_adj;

   genvar gi;
   generate
      for (gi = 0; gi < 5; gi++) begin : g_add3
         assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                     bcd_reg[gi*4 +: 4] + 4'd3 :
                                     bcd_reg[gi*4 +: 4];
      end
   endgenerate

   always_ff @(posedge clk_12m or posedge rst) begin
      if (rst) begin
         shift_reg <= '0;
         bcd_reg   <= '0;
         step_reg  <= '0;
         run_reg   <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         if (start) begin
            // First iteration folds into the load: the add-3 of an all-zero BCD is a no-op.
            bcd_reg   <= {19'd0, bin[15]};
            shift_reg <= {bin[14:0], 1'b0};
            step_reg  <= 4'd1;
            run_reg   <= 1'b1;
         end else if (run_reg) begin
            bcd_reg   <= {bcd_adj[18:0], shift_reg[15]};
            shift_reg <= {shift_reg[14:0], 1'b0};
            step_reg  <= step_reg + 4'd1;
            if (step_reg == 4'd15) begin
               run_reg  <= 1'b0;
               done_reg <= 1'b1;
            end
         end
      end
   end

   assign done = done_reg;
   assign bcd  = bcd_reg;

endmodule

// File: rtl/counter_report_sequencer.sv
// Emits "BTN=ddddd\r\n" for the button counter over a valid/ready byte stream,
// coalescing requests that arrive while a message is in progress.
module counter_report_sequencer
   import super_counter_pkg::*;
#(
   parameter int MIN_GAP_CYCLES = 0
) (
   input  logic        clk_12m,
   input  logic        rst,
   input  logic [15:0] count_i,
   input  logic        report_req_i,
   output logic [7:0]  tx_data_o,
   output logic        tx_valid_o,
   input  logic        tx_ready_i,
   output logic        busy_o,
   output logic        msg_done_o,
   output logic [7:0]  dropped_o
);

   localparam logic [15:0] GAP_LAST = (MIN_GAP_CYCLES > 0) ? 16'(MIN_GAP_CYCLES - 1) : 16'd0;
   localparam logic [3:0]  IDX_LAST = 4'(MSG_LEN - 1);

   seq_state_t  state_reg;
   logic [3:0]  idx_reg;
   logic [15:0] gap_cnt_reg;
   logic        pending_reg;
   logic [7:0]  dropped_reg;
   logic [7:0]  tx_data_reg;
   logic        tx_valid_reg;
   logic        busy_reg;
   logic        msg_done_reg;

   logic        start_conv;
   logic        conv_done;
   logic [19:0] conv_bcd;
   logic        xfer;

   assign start_conv = (state_reg == IDLE) && (report_req_i || pending_reg);
   assign xfer       = tx_valid_reg && tx_ready_i;

   bin16_to_bcd5 u_conv (
      .clk_12m (clk_12m),
      .rst     (rst),
      .start   (start_conv),
      .bin     (count_i),
      .done    (conv_done),
      .bcd     (conv_bcd)
   );

   function automatic logic [7:0] msg_byte(input logic [3:0] idx, input logic [19:0] digits);
      case (idx)
         4'd0:    return CHAR_B;
         4'd1:    return CHAR_T;
         4'd2:    return CHAR_N;
         4'd3:    return CHAR_EQ;
         4'd4:    return digit_char(digits[19:16]);
         4'd5:    return digit_char(digits[15:12]);
         4'd6:    return digit_char(digits[11:8]);
         4'd7:    return digit_char(digits[7:4]);
         4'd8:    return digit_char(digits[3:0]);
         4'd9:    return CHAR_CR;
         default: return CHAR_LF;
      endcase
   endfunction

   always_ff @(posedge clk_12m or posedge rst) begin
      if (rst) begin
         state_reg    <= IDLE;
         idx_reg      <= '0;
         gap_cnt_reg  <= '0;
         pending_reg  <= 1'b0;
         dropped_reg  <= '0;
         tx_data_reg  <= '0;
         tx_valid_reg <= 1'b0;
         busy_reg     <= 1'b0;
         msg_done_reg <= 1'b0;
      end else begin
         msg_done_reg <= 1'b0;

         // A start consumes pending; a request on that same cycle re-arms it.
         if (start_conv) begin
            pending_reg <= pending_reg && report_req_i;
         end else if (report_req_i) begin
            if (!pending_reg) begin
               pending_reg <= 1'b1;
            end else if (dropped_reg != 8'hFF) begin
               dropped_reg <= dropped_reg + 8'd1;
            end
         end

         case (state_reg)
            IDLE: begin
               if (start_conv) begin
                  state_reg <= CONVERT;
                  busy_reg  <= 1'b1;
               end
            end
            CONVERT: begin
               if (conv_done) begin
                  state_reg    <= SEND;
                  idx_reg      <= '0;
                  tx_valid_reg <= 1'b1;
                  tx_data_reg  <= msg_byte(4'd0, conv_bcd);
               end
            end
            SEND: begin
               if (xfer) begin
                  if (idx_reg == IDX_LAST) begin
                     tx_valid_reg <= 1'b0;
                     tx_data_reg  <= '0;
                     msg_done_reg <= 1'b1;
                     if (MIN_GAP_CYCLES > 0) begin
                        state_reg   <= GAP;
                        gap_cnt_reg <= '0;
                     end else begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                     end
                  end else begin
                     idx_reg     <= idx_reg + 4'd1;
                     tx_data_reg <= msg_byte(idx_reg + 4'd1, conv_bcd);
                  end
               end
            end
            GAP: begin
               if (gap_cnt_reg == GAP_LAST) begin
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
               end else begin
                  gap_cnt_reg <= gap_cnt_reg + 16'd1;
               end
            end
            default: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign tx_data_o  = tx_data_reg;
   assign tx_valid_o = tx_valid_reg;
   assign busy_o     = busy_reg;
   assign msg_done_o = msg_done_reg;
   assign dropped_o  = dropped_reg;

endmodule

// File: doc/counter_report_sequencer.md
# counter_report_sequencer

Schedules and serialises human-readable status reports of the 16-bit button counter onto a byte-wide UART transmit stream. On each report request it snapshots the counter, converts it to five decimal digits with a serial double-dabble converter, and emits the fixed 11-byte ASCII message "BTN=ddddd\r\n" through a valid/ready handshake. It sits between the super-counter datapath (count, press pulse) and the UART TX byte interface. It coalesces requests that arrive while busy and enforces a minimum idle gap between messages.

## Interface
- MIN_GAP_CYCLES, default 0: idle clocks inserted after the last byte of a message before the next message may start (0 = none).
- clk_12m  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- count_i  input  16  live button counter value.
- report_req_i  input  1  single-cycle request pulse; typically the debounced press pulse.
- tx_data_o  output  8  ASCII byte to UART TX.
- tx_valid_o  output  1  tx_data_o holds a valid byte.
- tx_ready_i  input  1  UART TX accepts the byte; transfer occurs when tx_valid_o && tx_ready_i.
- busy_o  output  1  high in any state other than IDLE.
- msg_done_o  output  1  one-cycle pulse after the final byte (0x0A) transfers.
- dropped_o  output  8  saturating count of requests discarded by coalescing.

## Operation
- FSM states: IDLE, CONVERT, SEND, GAP.
- IDLE: if report_req_i or pending is set, latch count_i into the snapshot, clear pending, start the converter, and go to CONVERT.
- CONVERT: the converter runs exactly 16 cycles (one shift/add-3 per input bit). On done, set byte index = 0 and go to SEND.
- SEND: tx_valid_o = 1. tx_data_o = message byte at the current index:
  - "B" 0x42, "T" 0x54, "N" 0x4E, "=" 0x3D,
  - digits ten-thousands to units as 0x30+d, always five digits with leading zeros,
  - 0x0D, 0x0A.
- SEND, byte transfer: on each transfer the index increments. On transfer of index 10, pulse msg_done_o next cycle and go to GAP if MIN_GAP_CYCLES>0, else to IDLE.
- GAP: count MIN_GAP_CYCLES clocks with tx_valid_o = 0, then go to IDLE.
- Pending and coalescing:
  - report_req_i in any state other than IDLE (or in IDLE on the same cycle pending is consumed) sets pending if pending is clear.
  - If pending is already set, the request is dropped and dropped_o increments, saturating at 255.
- The snapshot is taken when a message starts, never when its request arrives. A pending message therefore reports the count at its start.
- count_i changes during CONVERT or SEND do not affect the message in flight.

## Timing
- Reset values: tx_valid_o=0, tx_data_o=0x00, busy_o=0, msg_done_o=0, dropped_o=0, pending=0, state=IDLE.
- Reset is asynchronous: outputs go to reset values immediately. No partial message resumes after rst deasserts.
- Latency:
  - report_req_i sampled in IDLE at edge k: busy_o high after edge k.
  - First byte has tx_valid_o high after edge k+16.
  - With tx_ready_i held high, the last byte transfers at edge k+27 and msg_done_o is high for the cycle after edge k+27.
- Handshake rules:
  - tx_data_o and tx_valid_o are registered.
  - Once tx_valid_o rises, it and tx_data_o stay stable until the transfer.
  - tx_valid_o never drops mid-message without a transfer.
  - tx_ready_i may toggle arbitrarily.
- Back-to-back: with MIN_GAP_CYCLES=0 and pending set, IDLE lasts exactly one cycle between messages.
- Simultaneous events: a request in the same cycle as the final transfer sets pending.
- dropped_o: saturates at 255 and never wraps.

## Structure
- Shared package super_counter_pkg: state enum (IDLE, CONVERT, SEND, GAP), MSG_LEN=11, and ASCII constants (CHAR_B, CHAR_T, CHAR_N, CHAR_EQ, CHAR_0, CHAR_CR, CHAR_LF).
- Sub-module bin16_to_bcd5: serial double-dabble converter. Ports: clk_12m, rst, start, bin[15:0], done pulse, bcd[19:0]. Exactly 16 cycles from start to done.
- Top: FSM, byte index counter, gap counter, pending flag, dropped counter, and byte mux.

## Test plan
- count_i=42, one request, tx_ready_i=1 -> bytes 42 54 4E 3D 30 30 30 34 32 0D 0A, first valid 16 cycles after request, msg_done_o one pulse.
- count_i=65535 and count_i=0 -> digits "65535" and "00000" respectively.
- Random tx_ready_i stalls of 0-5 cycles per byte -> tx_data_o stable while stalled, exactly 11 transfers, correct order.
- During SEND, change count_i to 7 and pulse report_req_i 3 times -> current message unchanged, one follow-up message "BTN=00007\r\n", dropped_o=2.
- Assert rst during byte 5 of SEND -> tx_valid_o, busy_o and dropped_o go to 0 immediately. After release, a new request gives a complete, correct message.
- MIN_GAP_CYCLES=4 with pending set -> exactly 4 idle cycles after the 0x0A transfer plus 1 IDLE cycle before the next CONVERT.
